// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit internal bus. Registered one-hot
// tri-state driver enables, a turnaround gap after every release, and a MAX_HOLD revoke.
module bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         bus_en,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IDW = $clog2(N_REQ);
    localparam int HW  = $clog2(MAX_HOLD);
    localparam int TW  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0]  TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);
    localparam logic [IDW:0]   N_WIDE    = (IDW+1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [IDW-1:0]   owner_q,   owner_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;
    logic [IDW-1:0]   ptr_q,     ptr_d;
    logic [HW-1:0]    hold_q,    hold_d;
    logic [TW-1:0]    turn_q,    turn_d;

    logic             any_req;
    logic [IDW-1:0]   winner;

    // Circular first-set search starting at the priority pointer.
    always_comb begin
        logic [IDW:0] idx;
        idx     = '0;
        any_req = 1'b0;
        winner  = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (!any_req && req[idx[IDW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    owner_d         = winner;
                    busy_d          = 1'b1;
                    hold_d          = '0;
                    state_d         = GRANT;
                end
            end

            GRANT: begin
                // A release on the revoke cycle wins, so timeout only fires if req is still held.
                if (!req[owner_q] || (hold_q == HOLD_LAST)) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);
                    turn_d    = '0;
                    state_d   = TURN;
                    timeout_d = req[owner_q];
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end

            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
        end
    end

    assign grant    = grant_q;
    assign bus_en   = grant_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

    // Two enabled drivers would short the shared bus.
    a_onehot_en: assert property (@(posedge clk) disable iff (!rst_n) $countones(bus_en) <= 1);
    a_no_timeout_busy: assert property (@(posedge clk) disable iff (!rst_n) !(timeout && busy));

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised self-checking bench for bus_arbiter: an ownership-level reference
// model plus directed reset, round-robin, timeout, bus-sharing and mid-grant reset checks.
module tb_bus_arbiter;

    localparam int NREQ = 4;
    localparam int MAXH = 8;
    localparam int TURN = 1;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [3:0] busEn;
    logic [1:0] ownerId;
    logic       busy;
    logic       timeout;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: who owns the bus, for how many cycles, and how long until arbitration.
    int mValid = 0;
    int mOwner = 0;
    int mLastOwner = 0;
    int mHeld = 0;
    int mWait = 0;
    int mPtr = 0;
    int mTimeout = 0;

    logic [3:0] prevGrant = 4'b0000;
    int         zeroRun = 0;
    logic [3:0] grantOrder[$];
    int         gapLens[$];

    bus_arbiter #(
        .N_REQ(NREQ),
        .MAX_HOLD(MAXH),
        .TURN_CYCLES(TURN)
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .req(req),
        .grant(grant),
        .bus_en(busEn),
        .owner_id(ownerId),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input logic [3:0] r, input logic rn);
        mTimeout = 0;
        if (!rn) begin
            mValid = 0;
            mLastOwner = 0;
            mPtr = 0;
            mWait = 0;
            mHeld = 0;
        end else if (mValid != 0) begin
            if (!r[mOwner]) begin
                mValid = 0;
                mPtr = (mOwner + 1) % NREQ;
                mWait = TURN;
            end else if (mHeld == MAXH) begin
                mValid = 0;
                mPtr = (mOwner + 1) % NREQ;
                mWait = TURN;
                mTimeout = 1;
            end else begin
                mHeld++;
            end
        end else if (mWait > 0) begin
            mWait--;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (mPtr + k) % NREQ;
                if (r[c]) begin
                    mValid = 1;
                    mOwner = c;
                    mLastOwner = c;
                    mHeld = 1;
                    break;
                end
            end
        end
    endtask

    task automatic checkCycle();
        logic [3:0] expGrant;
        logic [8:0] expBus;
        logic [8:0] obsBus;
        expGrant = (mValid != 0) ? 4'(1 << mOwner) : 4'b0000;
        checkOutput("grant", 32'(grant), 32'(expGrant));
        checkOutput("busEn", 32'(busEn), 32'(expGrant));
        checkOutput("ownerId", 32'(ownerId), 32'(mLastOwner));
        checkOutput("busy", 32'(busy), 32'(mValid != 0));
        checkOutput("timeout", 32'(timeout), 32'(mTimeout));
        checkOutput("onehotInv", 32'($countones(busEn) <= 1), 32'd1);
        checkOutput("grantEnInv", 32'(grant == busEn), 32'd1);
        checkOutput("busyInv", 32'(busy), 32'(|grant));
        checkOutput("timeoutBusyInv", 32'(timeout & busy), 32'd0);
        // Only drivers 0 and 1 (values 02 and 03) sit on the bench's shared bus.
        obsBus = {busEn[0] | busEn[1], (busEn[0] ? 8'h02 : 8'h00) | (busEn[1] ? 8'h03 : 8'h00)};
        if (mValid != 0 && mOwner == 0) expBus = {1'b1, 8'h02};
        else if (mValid != 0 && mOwner == 1) expBus = {1'b1, 8'h03};
        else expBus = 9'h000;
        checkOutput("sharedBus", 32'(obsBus), 32'(expBus));
    endtask

    task automatic trackHistory();
        if (grant != 4'b0000 && prevGrant == 4'b0000) begin
            grantOrder.push_back(grant);
            gapLens.push_back(zeroRun);
        end
        if (grant == 4'b0000) zeroRun++;
        else zeroRun = 0;
        prevGrant = grant;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rn);
        req = r;
        rstN = rn;
        @(posedge clk);
        modelStep(r, rn);
        #1;
        checkCycle();
        trackHistory();
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] expOrder[5];
        int pulses;
        int firstRun;
        int seenTimeout;
        int alternates;

        $display("[TB] starting bus_arbiter bench");

        // Reset held with every requester asking.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput("rstGrant", 32'(grant), 32'd0);
        end
        applyStimulus(4'b1111, 1'b1);
        checkOutput("rstRelease", 32'(grant), 32'b0001);
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1);

        // Single request, release after three granted cycles, immediate re-request.
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("singleGrant", 32'(grant), 32'b0010);
        checkOutput("singleOwner", 32'(ownerId), 32'd1);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("singleDrop", 32'(busEn), 32'd0);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("singleGap", 32'(busEn), 32'd0);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("singleRegrant", 32'(grant), 32'b0010);

        // Round robin: everyone requests, each owner drops for one edge after two cycles.
        applyStimulus(4'b0000, 1'b0);
        grantOrder.delete();
        gapLens.delete();
        for (int c = 0; c < 80 && grantOrder.size() < 5; c++) begin
            r = 4'b1111;
            if (mValid != 0 && mHeld == 2) r[mOwner] = 1'b0;
            applyStimulus(r, 1'b1);
        end
        expOrder[0] = 4'b0001; expOrder[1] = 4'b0010; expOrder[2] = 4'b0100;
        expOrder[3] = 4'b1000; expOrder[4] = 4'b0001;
        checkOutput("rrCount", 32'(grantOrder.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("rrOrder", 32'((i < grantOrder.size()) ? grantOrder[i] : 4'b0000), 32'(expOrder[i]));
        end
        for (int i = 1; i < 5; i++) begin
            checkOutput("rrGap", (i < gapLens.size()) ? gapLens[i] : 0, 32'd2);
        end

        // Timeout: a lone requester holding on for 30 cycles gets revoked every 10.
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1);
        pulses = 0;
        firstRun = 0;
        seenTimeout = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(4'b0001, 1'b1);
            if (timeout) begin
                pulses++;
                seenTimeout = 1;
                checkOutput("timeoutGrant", 32'(grant), 32'd0);
            end
            if (seenTimeout == 0 && grant == 4'b0001) firstRun++;
        end
        checkOutput("holdLength", firstRun, 32'd8);
        checkOutput("timeoutPulses", pulses, 32'd3);

        // Two drivers sharing the bus must alternate ownership.
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1);
        grantOrder.delete();
        for (int i = 0; i < 40; i++) applyStimulus(4'b0011, 1'b1);
        alternates = 1;
        for (int i = 1; i < grantOrder.size(); i++) begin
            if (grantOrder[i] == grantOrder[i-1]) alternates = 0;
        end
        checkOutput("busOwners", 32'(grantOrder.size() >= 3), 32'd1);
        checkOutput("busAlternate", alternates, 32'd1);

        // Reset arriving in the middle of a grant.
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("midGrant", 32'(grant), 32'b0100);
        applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("midRstOut", 32'({grant, busEn, ownerId, busy, timeout}), 32'd0);
        applyStimulus(4'b0110, 1'b1);
        checkOutput("midRstPtr", 32'(grant), 32'b0010);

        // Random traffic with occasional resets.
        r = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            applyStimulus(r, ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
